// File: rtl/imem_sp_init.sv
// ============================================================================
//  imem_sp_init -- single-port instruction memory with self-clearing sweep
//  Single-port store with optional input/output pipeline stages and a clear
//  engine that writes INITVAL to every word after reset or on request.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module iramspx #(
   parameter int ADDRBIT = 11,
   parameter int DEPTH   = 1536,
   parameter int WIDTH   = 32
) (
   input  logic               clk,
   input  logic [ADDRBIT-1:0] a_i,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [WIDTH-1:0]   d_i,
   output logic [WIDTH-1:0]   q_o,
   input  logic               test_i,
   input  logic               mask_i
);
   logic [WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [WIDTH-1:0] q_q;

   // mask inhibits writes; test loops the data bus back onto the read port
   always_ff @(posedge clk) begin
      if (we_i && !mask_i) mem_q[a_i] <= d_i;
      if (re_i)            q_q <= test_i ? d_i : mem_q[a_i];
   end

   assign q_o = q_q;
endmodule

module imem_sp_init #(
   parameter int                ADDRBIT = 11,
   parameter int                DEPTH   = 1536,
   parameter int                WIDTH   = 32,
   parameter int                INREG   = 1,
   parameter int                OUTREG  = 1,
   parameter int                AUTOCLR = 1,
   parameter logic [WIDTH-1:0]  INITVAL = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDRBIT-1:0] a_i,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [WIDTH-1:0]   di_i,
   output logic [WIDTH-1:0]   do_o,
   output logic               dvld_o,
   input  logic               clr_i,
   output logic               busy_o,
   output logic               err_o,
   input  logic               test_i,
   input  logic               mask_i
);
   localparam logic [ADDRBIT:0]   c_depth = (ADDRBIT+1)'(DEPTH);
   localparam logic [ADDRBIT-1:0] c_last  = ADDRBIT'(DEPTH-1);

   typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [ADDRBIT-1:0] cnt_q, cnt_d;
   logic               auto_q;
   logic               err_q;
   logic               rv_q, roor_q;
   logic [WIDTH-1:0]   dout_q;

   logic               w_busy, w_start, w_block, w_inrange;
   logic               w_wr_a, w_rd_a, w_err_a;
   logic               w_b_wr, w_b_rd, w_b_oor;
   logic [ADDRBIT-1:0] w_b_a;
   logic [WIDTH-1:0]   w_b_di;
   logic [ADDRBIT-1:0] w_mem_a;
   logic               w_mem_we, w_mem_re;
   logic [WIDTH-1:0]   w_mem_d, w_mem_q, w_rdata;

   assign w_busy    = (state_q == CLEAR);
   assign w_start   = (state_q == IDLE) && (clr_i || auto_q);
   // The start cycle is also blocked so no user access is still in the
   // input stage when the sweep takes over the memory port.
   assign w_block   = w_busy || w_start;
   assign w_inrange = ({1'b0, a_i} < c_depth);
   assign w_wr_a    = we_i && !w_block && w_inrange;
   assign w_rd_a    = re_i && !we_i && !w_block;
   assign w_err_a   = (we_i || re_i) && (w_block || (we_i && re_i) || !w_inrange);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         auto_q  <= (AUTOCLR != 0);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         auto_q  <= 1'b0;
         err_q   <= w_err_a;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (w_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == c_last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   generate
      if (INREG != 0) begin : g_inreg
         logic               wr_q, rd_q, oor_q;
         logic [ADDRBIT-1:0] a_q;
         logic [WIDTH-1:0]   di_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_q  <= 1'b0;
               rd_q  <= 1'b0;
               oor_q <= 1'b0;
               a_q   <= '0;
               di_q  <= '0;
            end else begin
               wr_q  <= w_wr_a;
               rd_q  <= w_rd_a;
               oor_q <= !w_inrange;
               a_q   <= a_i;
               di_q  <= di_i;
            end
         end
         assign w_b_wr  = wr_q;
         assign w_b_rd  = rd_q;
         assign w_b_oor = oor_q;
         assign w_b_a   = a_q;
         assign w_b_di  = di_q;
      end else begin : g_noinreg
         assign w_b_wr  = w_wr_a;
         assign w_b_rd  = w_rd_a;
         assign w_b_oor = !w_inrange;
         assign w_b_a   = a_i;
         assign w_b_di  = di_i;
      end
   endgenerate

   assign w_mem_a  = w_busy ? cnt_q : w_b_a;
   assign w_mem_we = w_busy || w_b_wr;
   assign w_mem_d  = w_busy ? INITVAL : w_b_di;
   assign w_mem_re = w_b_rd && !w_b_oor;

   iramspx #(
      .ADDRBIT (ADDRBIT),
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH)
   ) u_ram (
      .clk    (clk),
      .a_i    (w_mem_a),
      .we_i   (w_mem_we),
      .re_i   (w_mem_re),
      .d_i    (w_mem_d),
      .q_o    (w_mem_q),
      .test_i (test_i),
      .mask_i (mask_i)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv_q   <= 1'b0;
         roor_q <= 1'b0;
      end else begin
         rv_q   <= w_b_rd;
         roor_q <= w_b_rd && w_b_oor;
      end
   end

   // Out-of-range reads never touch the array; they return zero in slot.
   assign w_rdata = roor_q ? '0 : w_mem_q;

   generate
      if (OUTREG != 0) begin : g_outreg
         logic dvld_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dvld_q <= 1'b0;
               dout_q <= '0;
            end else begin
               dvld_q <= rv_q;
               if (rv_q) dout_q <= w_rdata;
            end
         end
         assign do_o   = dout_q;
         assign dvld_o = dvld_q;
      end else begin : g_nooutreg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else if (rv_q) dout_q <= w_rdata;
         end
         assign do_o   = rv_q ? w_rdata : dout_q;
         assign dvld_o = rv_q;
      end
   endgenerate

   assign busy_o = w_busy;
   assign err_o  = err_q;
endmodule

`default_nettype wire
